chan_cfg_sequencer: RTL and testbench
=====================================

// Module: chan_cfg_sequencer
// PURPOSE
//  Downstream of the Ethernet config-packet parser. On the parser's one-cycle packet-valid pulse it:
//  - snapshots the general and per-channel config fields;
//  - range-checks them;
//  - delivers one config word per channel, in order, over a shared valid/ready bus to the channel DSP blocks.
//  Invalid packets are rejected whole, with no partial updates. Status and counters are kept for host readback.
// PARAMETERS
//  NUM_CH        4      channels served; channel index width CHW = 2
//  FFT_MIN_LOG2  6      smallest legal fft_size (log2 points)
//  FFT_MAX_LOG2  14     largest legal fft_size
//  MODE_MAX      3      largest legal mode code; 0 = channel disabled
//  TIMEOUT_CYC   16000  max cycles to wait for cfg_ready per channel
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous, active-high reset
//  pkt_valid      in   1          1-cycle pulse: parser fields are stable and the frame is valid
//  gen_num_ch     in   8          number of enabled channels in the packet
//  in_threshold   in   NUM_CH*32  per-channel threshold; ch k at [32k+31:32k]
//  in_mode        in   NUM_CH*8   per-channel mode
//  in_fft_size    in   NUM_CH*8   per-channel fft_size (log2)
//  in_freq        in   NUM_CH*32  per-channel tuning word
//  cfg_valid      out  1          config word on bus is valid
//  cfg_ready      in   1          channel block accepts word
//  cfg_ch         out  2          destination channel index
//  cfg_threshold  out  32         threshold for cfg_ch
//  cfg_mode       out  8          mode for cfg_ch (forced 0 when ch >= num_ch)
//  cfg_fft_size   out  8          fft_size for cfg_ch
//  cfg_freq       out  32         tuning word for cfg_ch
//  busy           out  1          sequence in progress
//  done           out  1          1-cycle pulse: all NUM_CH words accepted
//  err_code       out  2          last error: 0 none, 1 bad num_ch, 2 bad field, 3 timeout
//  commit_cnt     out  16         successful sequences (wraps at 0xFFFF->0)
//  drop_cnt       out  16         pkt_valid pulses ignored while busy (wraps)
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, snapshot cleared. Reset mid-sequence aborts immediately, with no further cfg_valid.
//  IDLE
//   - pkt_valid=1: latch all inputs into snapshot; -> CHECK.
//  CHECK (1 cycle)
//   - num_ch must be 1..NUM_CH, else err_code=1.
//   - For each k < num_ch: mode <= MODE_MAX and FFT_MIN_LOG2 <= fft_size <= FFT_MAX_LOG2, else err_code=2.
//   - Any error: -> IDLE. No cfg_valid is issued; commit_cnt is unchanged.
//   - Pass: ch=0, err_code=0; -> ISSUE.
//  ISSUE
//   - cfg_valid=1. Bus fields are driven from the snapshot for ch; channels k >= num_ch are sent with mode=0, other fields as captured.
//   - Bus fields are stable while cfg_valid=1 and cfg_ready=0.
//   - cfg_valid&cfg_ready: if ch==NUM_CH-1 -> DONE, else ch+1 with cfg_valid held high (back-to-back).
//   - Wait counter resets on each handshake. Reaching TIMEOUT_CYC without ready: cfg_valid drops next cycle, err_code=3, -> IDLE; earlier channels keep their new config.
//  DONE (1 cycle)
//   - done=1, commit_cnt+1; -> IDLE.
//  busy = (state != IDLE).
//  Latency: pulse in cycle T -> CHECK in T+1 -> ch0 valid in T+2. With ready tied 1, ch k accepted in T+2+k and done in T+2+NUM_CH.
//  Simultaneous events
//   - pkt_valid while busy (including CHECK and DONE): drop_cnt+1, pulse ignored, snapshot untouched.
//   - pkt_valid in the same cycle as rst: rst wins.
//   - Counters wrap silently.
//  err_code holds until the next CHECK; done never coincides with err_code != 0 being set.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE, CHECK, ISSUE, DONE), err_code values, FFT_MIN/MAX_LOG2, MODE_MAX, field widths.
//  Sub-module cfg_field_check: combinational range check of one channel's (mode, fft_size, enabled) -> ok. Instantiated NUM_CH times in a generate loop.
//  Snapshot registers, bus mux, FSM, timeout and counters are all in this module.
// TESTING
//  1. num_ch=2; ch0 mode1/fft10/freq 0x1000; ch1 mode2/fft12; cfg_ready=1; pulse at T
//     -> valid T+2..T+5, ch 0,1,2,3; ch2/ch3 mode=0; done at T+6; commit_cnt=1.
//  2. num_ch=0 (then 5) -> err_code=1, no cfg_valid, commit_cnt unchanged, busy for 1 cycle.
//  3. num_ch=4, ch3 fft_size=15 -> err_code=2, no channel updated.
//  4. Ready stalls: ready low 3 cycles per word -> fields stable while stalled, one handshake per channel, done after last.
//  5. Ready held 0 -> cfg_valid drops after exactly TIMEOUT_CYC cycles; err_code=3; next valid packet sequences normally.
//  6. Second pkt_valid during ISSUE -> drop_cnt=1, words reflect the first packet; rst asserted mid-ISSUE -> cfg_valid=0 next cycle, counters 0.

Source files
------------

// File: rtl/chan_cfg_sequencer_pkg.sv
// rtl/chan_cfg_sequencer_pkg.sv - shared widths, limits, FSM states and error codes
package chan_cfg_sequencer_pkg;
   localparam int NUM_CH       = 4;
   localparam int CHW          = 2;
   localparam int FFT_MIN_LOG2 = 6;
   localparam int FFT_MAX_LOG2 = 14;
   localparam int MODE_MAX     = 3;
   localparam int TIMEOUT_CYC  = 16000;

   localparam int GEN_W  = 8;
   localparam int THR_W  = 32;
   localparam int MODE_W = 8;
   localparam int FFT_W  = 8;
   localparam int FREQ_W = 32;
   localparam int CNT_W  = 16;
   localparam int WAIT_W = $clog2(TIMEOUT_CYC);

   localparam logic [MODE_W-1:0] MODE_MAX_V = MODE_W'(MODE_MAX);
   localparam logic [FFT_W-1:0]  FFT_MIN_V  = FFT_W'(FFT_MIN_LOG2);
   localparam logic [FFT_W-1:0]  FFT_MAX_V  = FFT_W'(FFT_MAX_LOG2);
   localparam logic [GEN_W-1:0]  NUM_CH_V   = GEN_W'(NUM_CH);
   localparam logic [CHW-1:0]    LAST_CH    = CHW'(NUM_CH - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_NUM_CH  = 2'd1,
      ERR_FIELD   = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_t;
endpackage

// File: rtl/chan_cfg_sequencer_cfg_field_check.sv
// rtl/chan_cfg_sequencer_cfg_field_check.sv - range check of one channel's mode and fft_size
module cfg_field_check
   import chan_cfg_sequencer_pkg::*;
(
   input  logic [MODE_W-1:0] mode,
   input  logic [FFT_W-1:0]  fft_size,
   input  logic              enabled,
   output logic              ok
);
   // Disabled channels are sent with mode forced to 0, so their captured fields never matter.
   assign ok = !enabled ||
               ((mode <= MODE_MAX_V) && (fft_size >= FFT_MIN_V) && (fft_size <= FFT_MAX_V));
endmodule

// File: rtl/chan_cfg_sequencer.sv
// rtl/chan_cfg_sequencer.sv - snapshots a config packet, validates it, issues one word per channel
module chan_cfg_sequencer
   import chan_cfg_sequencer_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pkt_valid,
   input  logic [GEN_W-1:0]         gen_num_ch,
   input  logic [NUM_CH*THR_W-1:0]  in_threshold,
   input  logic [NUM_CH*MODE_W-1:0] in_mode,
   input  logic [NUM_CH*FFT_W-1:0]  in_fft_size,
   input  logic [NUM_CH*FREQ_W-1:0] in_freq,
   output logic                     cfg_valid,
   input  logic                     cfg_ready,
   output logic [CHW-1:0]           cfg_ch,
   output logic [THR_W-1:0]         cfg_threshold,
   output logic [MODE_W-1:0]        cfg_mode,
   output logic [FFT_W-1:0]         cfg_fft_size,
   output logic [FREQ_W-1:0]        cfg_freq,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               err_code,
   output logic [CNT_W-1:0]         commit_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);
   state_t             state;
   logic [GEN_W-1:0]   snap_num_ch;
   logic [THR_W-1:0]   snap_thr  [NUM_CH];
   logic [MODE_W-1:0]  snap_mode [NUM_CH];
   logic [FFT_W-1:0]   snap_fft  [NUM_CH];
   logic [FREQ_W-1:0]  snap_freq [NUM_CH];
   logic [WAIT_W-1:0]  wait_cnt;
   logic [NUM_CH-1:0]  field_ok;
   logic               num_ok;
   logic [CHW-1:0]     next_ch;
   logic [MODE_W-1:0]  next_mode;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_chk
      cfg_field_check u_chk (
         .mode     (snap_mode[k]),
         .fft_size (snap_fft[k]),
         .enabled  (GEN_W'(k) < snap_num_ch),
         .ok       (field_ok[k])
      );
   end

   assign num_ok = (snap_num_ch != '0) && (snap_num_ch <= NUM_CH_V);
   assign busy   = (state != ST_IDLE);

   // Channel whose word is loaded onto the bus at the next edge: 0 when leaving CHECK, else ch+1.
   always_comb begin
      next_ch   = (state == ST_CHECK) ? '0 : cfg_ch + CHW'(1);
      next_mode = ({{(GEN_W-CHW){1'b0}}, next_ch} < snap_num_ch) ? snap_mode[next_ch] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         snap_num_ch   <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            snap_thr[k]  <= '0;
            snap_mode[k] <= '0;
            snap_fft[k]  <= '0;
            snap_freq[k] <= '0;
         end
         wait_cnt      <= '0;
         cfg_valid     <= 1'b0;
         cfg_ch        <= '0;
         cfg_threshold <= '0;
         cfg_mode      <= '0;
         cfg_fft_size  <= '0;
         cfg_freq      <= '0;
         done          <= 1'b0;
         err_code      <= ERR_NONE;
         commit_cnt    <= '0;
         drop_cnt      <= '0;
      end else begin
         done <= 1'b0;
         if (pkt_valid && state != ST_IDLE) drop_cnt <= drop_cnt + CNT_W'(1);
         case (state)
            ST_IDLE: begin
               if (pkt_valid) begin
                  snap_num_ch <= gen_num_ch;
                  for (int k = 0; k < NUM_CH; k++) begin
                     snap_thr[k]  <= in_threshold[THR_W*k +: THR_W];
                     snap_mode[k] <= in_mode[MODE_W*k +: MODE_W];
                     snap_fft[k]  <= in_fft_size[FFT_W*k +: FFT_W];
                     snap_freq[k] <= in_freq[FREQ_W*k +: FREQ_W];
                  end
                  state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!num_ok) begin
                  err_code <= ERR_NUM_CH;
                  state    <= ST_IDLE;
               end else if (!(&field_ok)) begin
                  err_code <= ERR_FIELD;
                  state    <= ST_IDLE;
               end else begin
                  err_code      <= ERR_NONE;
                  cfg_valid     <= 1'b1;
                  cfg_ch        <= next_ch;
                  cfg_threshold <= snap_thr[next_ch];
                  cfg_mode      <= next_mode;
                  cfg_fft_size  <= snap_fft[next_ch];
                  cfg_freq      <= snap_freq[next_ch];
                  wait_cnt      <= '0;
                  state         <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (cfg_ready) begin
                  wait_cnt <= '0;
                  if (cfg_ch == LAST_CH) begin
                     cfg_valid  <= 1'b0;
                     done       <= 1'b1;
                     commit_cnt <= commit_cnt + CNT_W'(1);
                     state      <= ST_DONE;
                  end else begin
                     cfg_ch        <= next_ch;
                     cfg_threshold <= snap_thr[next_ch];
                     cfg_mode      <= next_mode;
                     cfg_fft_size  <= snap_fft[next_ch];
                     cfg_freq      <= snap_freq[next_ch];
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  // Words already accepted stay applied downstream; only the rest is abandoned.
                  cfg_valid <= 1'b0;
                  err_code  <= ERR_TIMEOUT;
                  state     <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_chan_cfg_sequencer.sv
// tb/tb_chan_cfg_sequencer.sv - randomized self-checking bench for chan_cfg_sequencer
module tb_chan_cfg_sequencer;
   localparam int NCH = 4;
   localparam int TMO = 16000;

   logic           clk = 1'b0;
   logic           rst, pkt_valid, cfg_ready;
   logic [7:0]     gen_num_ch;
   logic [NCH*32-1:0] in_threshold, in_freq;
   logic [NCH*8-1:0]  in_mode, in_fft_size;
   logic           cfg_valid, busy, done;
   logic [1:0]     cfg_ch, err_code;
   logic [31:0]    cfg_threshold, cfg_freq;
   logic [7:0]     cfg_mode, cfg_fft_size;
   logic [15:0]    commit_cnt, drop_cnt;

   always #5 clk = ~clk;

   chan_cfg_sequencer dut (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .gen_num_ch(gen_num_ch),
      .in_threshold(in_threshold), .in_mode(in_mode), .in_fft_size(in_fft_size), .in_freq(in_freq),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_threshold(cfg_threshold),
      .cfg_mode(cfg_mode), .cfg_fft_size(cfg_fft_size), .cfg_freq(cfg_freq),
      .busy(busy), .done(done), .err_code(err_code), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
   );

   typedef struct packed {
      logic [1:0]  ch;
      logic [31:0] thr;
      logic [7:0]  mode;
      logic [7:0]  fft;
      logic [31:0] freq;
   } word_t;

   int errors = 0;
   int checks = 0;
   int exp_commit = 0;
   int exp_drop = 0;

   logic [7:0]  p_num;
   logic [31:0] p_thr  [NCH];
   logic [7:0]  p_mode [NCH];
   logic [7:0]  p_fft  [NCH];
   logic [31:0] p_freq [NCH];

   word_t obs_q[$];
   int r_first_valid, r_valid_cycles, r_done_cyc, r_done_count, r_busy_cycles;
   int r_end_cyc, r_stall_bad, r_last_hs;
   bit r_expired;

   // Reference: rules applied directly to the packet contents.
   function automatic int model_err();
      if (p_num < 1 || p_num > NCH) return 1;
      for (int k = 0; k < int'(p_num); k++)
         if (p_mode[k] > 3 || p_fft[k] < 6 || p_fft[k] > 14) return 2;
      return 0;
   endfunction

   function automatic word_t exp_word(input int k);
      word_t w;
      w.ch   = 2'(k);
      w.thr  = p_thr[k];
      w.mode = (k < int'(p_num)) ? p_mode[k] : 8'd0;
      w.fft  = p_fft[k];
      w.freq = p_freq[k];
      return w;
   endfunction

   task automatic rand_pkt(input bit all_legal);
      if (all_legal || $urandom_range(0, 9) < 8) p_num = 8'($urandom_range(1, NCH));
      else if ($urandom_range(0, 1) == 1) p_num = 8'd0;
      else p_num = 8'($urandom_range(5, 255));
      for (int k = 0; k < NCH; k++) begin
         p_thr[k]  = $urandom;
         p_freq[k] = $urandom;
         if (all_legal || $urandom_range(0, 9) < 8) begin
            p_mode[k] = 8'($urandom_range(0, 3));
            p_fft[k]  = 8'($urandom_range(6, 14));
         end else begin
            p_mode[k] = 8'($urandom_range(0, 255));
            p_fft[k]  = 8'($urandom_range(0, 255));
         end
      end
   endtask

   task automatic drive_pkt();
      gen_num_ch = p_num;
      for (int k = 0; k < NCH; k++) begin
         in_threshold[32*k +: 32] = p_thr[k];
         in_mode[8*k +: 8]        = p_mode[k];
         in_fft_size[8*k +: 8]    = p_fft[k];
         in_freq[32*k +: 32]      = p_freq[k];
      end
      pkt_valid = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pkt_valid = 1'b0;
      cfg_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_commit = 0;
      exp_drop = 0;
   endtask

   // ready_mode: 0 always ready, 1 three stall cycles per word, 2 random, 3 accept first word only.
   task automatic run_seq(input int ready_mode, input int inject_cyc, input int budget);
      word_t cur, prev;
      bit prev_stall, rdy;
      int stall_ctr;
      obs_q.delete();
      r_first_valid = -1; r_valid_cycles = 0; r_done_cyc = -1; r_done_count = 0;
      r_busy_cycles = 0; r_end_cyc = -1; r_stall_bad = 0; r_last_hs = -1;
      r_expired = 1'b1; prev_stall = 1'b0; stall_ctr = 0; prev = '0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(posedge clk);
         #1;
         cur = {cfg_ch, cfg_threshold, cfg_mode, cfg_fft_size, cfg_freq};
         if (!busy) begin
            r_end_cyc = cyc;
            r_expired = 1'b0;
            pkt_valid = 1'b0;
            break;
         end
         r_busy_cycles++;
         pkt_valid = (cyc == inject_cyc);
         if (cyc == inject_cyc) begin
            gen_num_ch   = 8'($urandom);
            in_threshold = {$urandom, $urandom, $urandom, $urandom};
            in_freq      = {$urandom, $urandom, $urandom, $urandom};
            in_mode      = $urandom;
            in_fft_size  = $urandom;
         end
         if (done) begin
            r_done_count++;
            if (r_done_cyc < 0) r_done_cyc = cyc;
         end
         if (prev_stall && cfg_valid && cur !== prev) r_stall_bad++;
         if (cfg_valid) begin
            if (r_first_valid < 0) r_first_valid = cyc;
            r_valid_cycles++;
            case (ready_mode)
               0: rdy = 1'b1;
               1: rdy = (stall_ctr >= 3);
               2: rdy = 1'($urandom_range(0, 1));
               default: rdy = (obs_q.size() == 0);
            endcase
            cfg_ready = rdy;
            if (rdy) begin
               obs_q.push_back(cur);
               r_last_hs = cyc;
               stall_ctr = 0;
            end else begin
               stall_ctr++;
            end
            prev_stall = !rdy;
            prev = cur;
         end else begin
            cfg_ready = 1'($urandom_range(0, 1));
            prev_stall = 1'b0;
         end
      end
      cfg_ready = 1'b0;
      pkt_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid got=%b exp=0", cfg_valid); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
      checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_code); end
      checks++; if (commit_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", commit_cnt, drop_cnt); end
      checks++; if ({cfg_ch, cfg_threshold, cfg_mode, cfg_fft_size, cfg_freq} !== '0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {cfg_ch, cfg_threshold, cfg_mode, cfg_fft_size, cfg_freq}); end
   endtask

   task automatic test_basic();
      rand_pkt(1'b1);
      p_num = 8'd2;
      p_mode[0] = 8'd1; p_fft[0] = 8'd10; p_freq[0] = 32'h1000;
      p_mode[1] = 8'd2; p_fft[1] = 8'd12;
      p_mode[2] = 8'd200; p_fft[2] = 8'd15;
      p_mode[3] = 8'd9;   p_fft[3] = 8'd1;
      drive_pkt();
      run_seq(0, 0, 40);
      exp_commit++;
      checks++; if (r_expired) begin errors++; $display("FAIL basic_hang got=expired exp=idle"); end
      checks++; if (r_first_valid !== 2) begin errors++; $display("FAIL basic_first_valid got=%0d exp=2", r_first_valid); end
      checks++; if (r_valid_cycles !== NCH) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=%0d", r_valid_cycles, NCH); end
      checks++; if (r_done_cyc !== 2 + NCH || r_done_count !== 1) begin errors++; $display("FAIL basic_done got=%0d x%0d exp=%0d x1", r_done_cyc, r_done_count, 2 + NCH); end
      checks++; if (obs_q.size() !== NCH) begin errors++; $display("FAIL basic_words got=%0d exp=%0d", obs_q.size(), NCH); end
      for (int k = 0; k < NCH && k < obs_q.size(); k++) begin
         checks++; if (obs_q[k] !== exp_word(k)) begin errors++; $display("FAIL basic_word%0d got=%h exp=%h", k, obs_q[k], exp_word(k)); end
      end
      checks++; if (int'(commit_cnt) !== exp_commit || err_code !== 2'd0) begin errors++; $display("FAIL basic_commit got=%0d err=%0d exp=%0d err=0", commit_cnt, err_code, exp_commit); end
   endtask

   task automatic test_bad_num_ch();
      int bad [3] = '{0, 5, 255};
      for (int i = 0; i < 3; i++) begin
         rand_pkt(1'b1);
         p_num = 8'(bad[i]);
         drive_pkt();
         run_seq(0, 0, 20);
         checks++; if (r_valid_cycles !== 0) begin errors++; $display("FAIL badnum%0d_valid got=%0d exp=0", bad[i], r_valid_cycles); end
         checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL badnum%0d_err got=%0d exp=1", bad[i], err_code); end
         checks++; if (r_busy_cycles !== 1) begin errors++; $display("FAIL badnum%0d_busy got=%0d exp=1", bad[i], r_busy_cycles); end
         checks++; if (int'(commit_cnt) !== exp_commit) begin errors++; $display("FAIL badnum%0d_commit got=%0d exp=%0d", bad[i], commit_cnt, exp_commit); end
      end
   endtask

   task automatic test_bad_field();
      int e;
      for (int i = 0; i < 4; i++) begin
         rand_pkt(1'b1);
         p_num = 8'd4;
         case (i)
            0: p_fft[3] = 8'd15;
            1: p_mode[0] = 8'd4;
            2: p_fft[1] = 8'd5;
            default: begin p_mode[2] = 8'd3; p_fft[2] = 8'd6; p_fft[3] = 8'd14; end
         endcase
         e = model_err();
         drive_pkt();
         run_seq(0, 0, 40);
         if (e == 0) exp_commit++;
         checks++; if (int'(err_code) !== e) begin errors++; $display("FAIL field%0d_err got=%0d exp=%0d", i, err_code, e); end
         checks++; if (r_valid_cycles !== (e == 0 ? NCH : 0)) begin errors++; $display("FAIL field%0d_valid got=%0d exp=%0d", i, r_valid_cycles, (e == 0 ? NCH : 0)); end
         checks++; if (int'(commit_cnt) !== exp_commit) begin errors++; $display("FAIL field%0d_commit got=%0d exp=%0d", i, commit_cnt, exp_commit); end
      end
   endtask

   task automatic test_stalls();
      rand_pkt(1'b1);
      drive_pkt();
      run_seq(1, 0, 100);
      exp_commit++;
      checks++; if (obs_q.size() !== NCH) begin errors++; $display("FAIL stall_words got=%0d exp=%0d", obs_q.size(), NCH); end
      for (int k = 0; k < NCH && k < obs_q.size(); k++) begin
         checks++; if (obs_q[k] !== exp_word(k)) begin errors++; $display("FAIL stall_word%0d got=%h exp=%h", k, obs_q[k], exp_word(k)); end
      end
      checks++; if (r_stall_bad !== 0) begin errors++; $display("FAIL stall_stable got=%0d exp=0", r_stall_bad); end
      checks++; if (r_valid_cycles !== 4 * NCH) begin errors++; $display("FAIL stall_valid_cycles got=%0d exp=%0d", r_valid_cycles, 4 * NCH); end
      checks++; if (r_done_cyc !== r_last_hs + 1 || r_done_count !== 1) begin errors++; $display("FAIL stall_done got=%0d x%0d exp=%0d x1", r_done_cyc, r_done_count, r_last_hs + 1); end
      checks++; if (int'(commit_cnt) !== exp_commit) begin errors++; $display("FAIL stall_commit got=%0d exp=%0d", commit_cnt, exp_commit); end
   endtask

   task automatic test_timeout();
      rand_pkt(1'b1);
      p_num = 8'd4;
      drive_pkt();
      run_seq(3, 0, TMO + 50);
      checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL tmo_words got=%0d exp=1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         checks++; if (obs_q[0] !== exp_word(0)) begin errors++; $display("FAIL tmo_word0 got=%h exp=%h", obs_q[0], exp_word(0)); end
      end
      checks++; if (r_valid_cycles !== 1 + TMO) begin errors++; $display("FAIL tmo_valid_cycles got=%0d exp=%0d", r_valid_cycles, 1 + TMO); end
      checks++; if (r_end_cyc !== TMO + 3) begin errors++; $display("FAIL tmo_idle_cyc got=%0d exp=%0d", r_end_cyc, TMO + 3); end
      checks++; if (err_code !== 2'd3 || r_done_count !== 0) begin errors++; $display("FAIL tmo_err got=%0d done=%0d exp=3 done=0", err_code, r_done_count); end
      checks++; if (int'(commit_cnt) !== exp_commit) begin errors++; $display("FAIL tmo_commit got=%0d exp=%0d", commit_cnt, exp_commit); end
      rand_pkt(1'b1);
      drive_pkt();
      run_seq(0, 0, 40);
      exp_commit++;
      checks++; if (obs_q.size() !== NCH || err_code !== 2'd0) begin errors++; $display("FAIL tmo_recover got=%0d err=%0d exp=%0d err=0", obs_q.size(), err_code, NCH); end
      checks++; if (int'(commit_cnt) !== exp_commit) begin errors++; $display("FAIL tmo_recover_commit got=%0d exp=%0d", commit_cnt, exp_commit); end
   endtask

   task automatic test_drop_and_rst();
      int inj [3] = '{1, 3, 6};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         rand_pkt(1'b1);
         drive_pkt();
         run_seq(0, inj[i], 40);
         exp_drop++;
         exp_commit++;
         checks++; if (int'(drop_cnt) !== exp_drop) begin errors++; $display("FAIL drop%0d_cnt got=%0d exp=%0d", inj[i], drop_cnt, exp_drop); end
         checks++; if (obs_q.size() !== NCH || int'(commit_cnt) !== exp_commit) begin errors++; $display("FAIL drop%0d_seq got=%0d/%0d exp=%0d/%0d", inj[i], obs_q.size(), commit_cnt, NCH, exp_commit); end
         for (int k = 0; k < NCH && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_word(k)) begin errors++; $display("FAIL drop%0d_word%0d got=%h exp=%h", inj[i], k, obs_q[k], exp_word(k)); end
         end
      end
      rand_pkt(1'b1);
      drive_pkt();
      @(posedge clk); #1; pkt_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", cfg_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_commit = 0; exp_drop = 0;
      checks++; if (cfg_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid got=%b%b exp=00", cfg_valid, busy); end
      checks++; if (commit_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnts got=%0d/%0d exp=0/0", commit_cnt, drop_cnt); end
      rst = 1'b1;
      drive_pkt();
      @(posedge clk); #1;
      rst = 1'b0; pkt_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || cfg_valid !== 1'b0) begin errors++; $display("FAIL rst_wins got=%b%b exp=00", busy, cfg_valid); end
   endtask

   task automatic test_random();
      int e;
      for (int i = 0; i < 40; i++) begin
         rand_pkt(1'b0);
         e = model_err();
         drive_pkt();
         run_seq(2, 0, 300);
         if (e == 0) exp_commit++;
         checks++; if (r_expired || int'(err_code) !== e) begin errors++; $display("FAIL rnd%0d_err got=%0d exp=%0d", i, err_code, e); end
         checks++; if (obs_q.size() !== (e == 0 ? NCH : 0) || r_stall_bad !== 0) begin errors++; $display("FAIL rnd%0d_words got=%0d stall=%0d exp=%0d stall=0", i, obs_q.size(), r_stall_bad, (e == 0 ? NCH : 0)); end
         for (int k = 0; k < obs_q.size() && k < NCH; k++) begin
            checks++; if (obs_q[k] !== exp_word(k)) begin errors++; $display("FAIL rnd%0d_word%0d got=%h exp=%h", i, k, obs_q[k], exp_word(k)); end
         end
         checks++; if (int'(commit_cnt) !== exp_commit) begin errors++; $display("FAIL rnd%0d_commit got=%0d exp=%0d", i, commit_cnt, exp_commit); end
      end
   endtask

   initial begin
      rst = 1'b1; pkt_valid = 1'b0; cfg_ready = 1'b0; gen_num_ch = '0;
      in_threshold = '0; in_mode = '0; in_fft_size = '0; in_freq = '0;
      test_reset();
      test_basic();
      test_bad_num_ch();
      test_bad_field();
      test_stalls();
      test_timeout();
      test_drop_and_rst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
